// File: rtl/eth_l2_pkg.sv
// Shared L2 transmit-path definitions: arbiter state encoding and Ethernet framing constants.
package eth_l2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_SOF,
        ST_XFER,
        ST_DRAIN,
        ST_GAP
    } arb_state_t;

    localparam int ETH_PREAMBLE_BYTES = 8;
    localparam int ETH_CRC_BYTES      = 4;
    localparam int ETH_IFG_BYTES      = 12;
    localparam int ETH_MAX_FRAME      = 1514;

    // The MII output moves one nibble per Clk, so every idle byte costs two cycles.
    localparam int ETH_IFG_CYCLES = 2 * (ETH_PREAMBLE_BYTES + ETH_CRC_BYTES + ETH_IFG_BYTES);

endpackage

// File: rtl/eth_frame_arbiter_rr_pick.sv
// Combinational round-robin selector: first asserted request at or after ptr, wrapping modulo N.
module rr_pick #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          valid
);

    int            cand;
    logic [PW-1:0] cand_idx;

    // NOTE: every variable gets a default before the loop, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        gnt      = '0;
        idx      = '0;
        valid    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 0; k < N; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N) cand = cand - N;
            cand_idx = PW'(cand);
            if (!valid && req[cand_idx]) begin
                valid         = 1'b1;
                gnt[cand_idx] = 1'b1;
                idx           = cand_idx;
            end
        end
    end

endmodule

// File: rtl/eth_frame_arbiter.sv
// Frame-level round-robin arbiter in front of the shared L2 transmit path.
// Optional frame statistics counter is built only when ETH_ARB_STATS_EN is defined.
module eth_frame_arbiter
    import eth_l2_pkg::*;
#(
    parameter int NUM_REQ         = 2,
    parameter int IFG_CYCLES      = ETH_IFG_CYCLES,
    parameter int GRANT_TIMEOUT   = 255,
    parameter int MAX_FRAME_BYTES = ETH_MAX_FRAME
) (
    input  logic                 Clk,
    input  logic                 RstN,
    input  logic                 LINK_UP,
    input  logic [NUM_REQ-1:0]   ReqIn,
    input  logic [NUM_REQ-1:0]   ValIn,
    input  logic [NUM_REQ-1:0]   SoFIn,
    input  logic [NUM_REQ-1:0]   EoFIn,
    input  logic [8*NUM_REQ-1:0] DataIn,
    output logic [NUM_REQ-1:0]   ReqConfirm,
    output logic                 ValOut,
    output logic                 SoFOut,
    output logic                 EoFOut,
    output logic [7:0]           DataOut,
    output logic                 ErrTimeout,
    output logic                 ErrOverLen,
    output logic [15:0]          StatFrames
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int LEN_W = $clog2(MAX_FRAME_BYTES + 1);
    localparam int TMO_W = $clog2(GRANT_TIMEOUT + 1);
    localparam int GAP_W = $clog2(IFG_CYCLES + 1);

    arb_state_t       state;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] gnt_idx;
    logic [LEN_W-1:0] len_cnt;
    logic [LEN_W-1:0] len_inc;
    logic [TMO_W-1:0] tmo_cnt;
    logic [GAP_W-1:0] gap_cnt;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_valid;

    logic       sel_val;
    logic       sel_sof;
    logic       sel_eof;
    logic [7:0] sel_data;

    rr_pick #(
        .N  (NUM_REQ),
        .PW (PTR_W)
    ) u_rr_pick (
        .req   (ReqIn),
        .ptr   (ptr),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // Only the current grantee's lane is ever looked at.
    always_comb begin
        sel_val  = ValIn[gnt_idx];
        sel_sof  = SoFIn[gnt_idx];
        sel_eof  = EoFIn[gnt_idx];
        sel_data = DataIn[{gnt_idx, 3'b000} +: 8];
    end

    assign len_inc = len_cnt + LEN_W'(1);

    // NOTE: synchronous reset sampled on Clk; all state and outputs use non-blocking assignments.
    always_ff @(posedge Clk) begin
        if (!RstN) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            gnt_idx    <= '0;
            len_cnt    <= '0;
            tmo_cnt    <= '0;
            gap_cnt    <= '0;
            ReqConfirm <= '0;
            ValOut     <= 1'b0;
            SoFOut     <= 1'b0;
            EoFOut     <= 1'b0;
            DataOut    <= '0;
            ErrTimeout <= 1'b0;
            ErrOverLen <= 1'b0;
        end else begin
            ValOut     <= 1'b0;
            SoFOut     <= 1'b0;
            EoFOut     <= 1'b0;
            ErrTimeout <= 1'b0;
            ErrOverLen <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (LINK_UP && pick_valid) begin
                        ReqConfirm <= pick_gnt;
                        gnt_idx    <= pick_idx;
                        ptr        <= (pick_idx == PTR_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
                        tmo_cnt    <= '0;
                        state      <= ST_WAIT_SOF;
                    end
                end
                ST_WAIT_SOF: begin
                    if (sel_val && sel_sof) begin
                        ValOut  <= 1'b1;
                        SoFOut  <= 1'b1;
                        EoFOut  <= sel_eof;
                        DataOut <= sel_data;
                        len_cnt <= LEN_W'(1);
                        if (sel_eof) begin
                            ReqConfirm <= '0;
                            gap_cnt    <= '0;
                            state      <= ST_GAP;
                        end else begin
                            state <= ST_XFER;
                        end
                    end else if (tmo_cnt == TMO_W'(GRANT_TIMEOUT - 1)) begin
                        // The grantee has had GRANT_TIMEOUT cycles with ReqConfirm high.
                        ReqConfirm <= '0;
                        ErrTimeout <= 1'b1;
                        state      <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_XFER: begin
                    if (sel_val) begin
                        ValOut  <= 1'b1;
                        DataOut <= sel_data;
                        len_cnt <= len_inc;
                        if (sel_eof) begin
                            EoFOut     <= 1'b1;
                            ReqConfirm <= '0;
                            gap_cnt    <= '0;
                            state      <= ST_GAP;
                        end else if (len_inc == LEN_W'(MAX_FRAME_BYTES)) begin
                            EoFOut     <= 1'b1;
                            ErrOverLen <= 1'b1;
                            state      <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Grant is held so the requester can flush the rest of its oversize frame.
                    if (sel_val && sel_eof) begin
                        ReqConfirm <= '0;
                        gap_cnt    <= '0;
                        state      <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    // First GAP cycle carries EoFOut; the IFG count starts on the one after.
                    if (gap_cnt == GAP_W'(IFG_CYCLES)) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef ETH_ARB_STATS_EN
    always_ff @(posedge Clk) begin
        if (!RstN) begin
            StatFrames <= '0;
        end else if (EoFOut) begin
            StatFrames <= StatFrames + 16'd1;
        end
    end
`else
    assign StatFrames = '0;
`endif

endmodule
